// File: rtl/led_chain_streamer.sv
// led_chain_streamer
//   Snapshots N_LEDS colour frames of W bits from a flat bus on a start
//   request and serialises them onto a single-wire NRZ pulse-width line
//   (WS2812-class). Each bit is a high phase followed by a low phase whose
//   lengths depend on the bit value. The last bit is followed by a low
//   latch gap of T_RST cycles.
//
// Ports
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   frames   : frame for LED i at bits [i*W+W-1 : i*W]
//   start    : refresh request, sampled only when idle
//   dout     : serial line to the LED chain (registered)
//   busy     : high while bits or the latch gap are being sent
//   done     : one-cycle pulse when the refresh completes
//   led_idx  : index of the LED whose frame is on the line
module led_chain_streamer #(
  parameter int N_LEDS    = 8,
  parameter int W         = 24,
  parameter int MSB_FIRST = 1,
  parameter int T0H       = 20,
  parameter int T0L       = 43,
  parameter int T1H       = 40,
  parameter int T1L       = 23,
  parameter int T_RST     = 2500,
  localparam int LW       = (N_LEDS > 1) ? $clog2(N_LEDS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_LEDS*W-1:0] frames,
  input  logic                start,
  output logic                dout,
  output logic                busy,
  output logic                done,
  output logic [LW-1:0]       led_idx
);

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int NW   = N_LEDS * W;
  localparam int TMAX = imax(imax(imax(T0H, T0L), imax(T1H, T1L)), T_RST);
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int BW   = (W > 1) ? $clog2(W) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_HIGH  = 2'd1;
  localparam logic [1:0] S_LOW   = 2'd2;
  localparam logic [1:0] S_LATCH = 2'd3;

  logic [1:0]    state;
  logic [NW-1:0] snap;
  logic [BW-1:0] bit_cnt;   // bits already completed within the current frame
  logic [TW-1:0] timer;     // remaining cycles of the current phase, minus one
  logic          first_bit;
  logic          cur_bit;
  logic          next_bit;
  logic          last_bit;
  logic          last_led;

  // Bit_cnt counts transmission order; the physical bit position inside the
  // frame is mirrored for MSB-first operation.
  function automatic logic frame_bit(input logic [NW-1:0] s,
                                     input logic [LW-1:0] led,
                                     input logic [BW-1:0] cnt);
    int            pos;
    logic [NW-1:0] sh;
    pos = int'(led) * W + ((MSB_FIRST != 0) ? (W - 1 - int'(cnt)) : int'(cnt));
    sh  = s >> pos;
    return sh[0];
  endfunction

  function automatic logic [TW-1:0] high_time(input logic b);
    return b ? TW'(T1H - 1) : TW'(T0H - 1);
  endfunction

  function automatic logic [TW-1:0] low_time(input logic b);
    return b ? TW'(T1L - 1) : TW'(T0L - 1);
  endfunction

  assign first_bit = frame_bit(frames, '0, '0);
  assign cur_bit   = frame_bit(snap, led_idx, bit_cnt);
  assign last_bit  = (bit_cnt == BW'(W - 1));
  assign last_led  = (led_idx == LW'(N_LEDS - 1));

  // Value of the bit that follows the current one, so its high time can be
  // loaded on the same edge that ends the current low phase (no gaps).
  always_comb begin
    next_bit = 1'b0;
    if (last_bit) begin
      next_bit = frame_bit(snap, led_idx + 1'b1, '0);
    end else begin
      next_bit = frame_bit(snap, led_idx, bit_cnt + 1'b1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      snap    <= '0;
      bit_cnt <= '0;
      timer   <= '0;
      dout    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      led_idx <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            snap    <= frames;
            led_idx <= '0;
            bit_cnt <= '0;
            timer   <= high_time(first_bit);
            state   <= S_HIGH;
            dout    <= 1'b1;
            busy    <= 1'b1;
          end
        end
        S_HIGH: begin
          if (timer == '0) begin
            state <= S_LOW;
            dout  <= 1'b0;
            timer <= low_time(cur_bit);
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_LOW: begin
          if (timer == '0) begin
            if (!last_bit) begin
              bit_cnt <= bit_cnt + 1'b1;
              state   <= S_HIGH;
              dout    <= 1'b1;
              timer   <= high_time(next_bit);
            end else if (!last_led) begin
              led_idx <= led_idx + 1'b1;
              bit_cnt <= '0;
              state   <= S_HIGH;
              dout    <= 1'b1;
              timer   <= high_time(next_bit);
            end else begin
              state <= S_LATCH;
              timer <= TW'(T_RST - 1);
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_LATCH: begin
          if (timer == '0) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
            led_idx <= '0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          dout  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_chain_streamer.sv
// tb_led_chain_streamer
//   Directed bench for led_chain_streamer with N_LEDS=2, W=4, T0H=1, T0L=3,
//   T1H=3, T1L=1, T_RST=5. Instance dut_a is MSB-first, dut_b LSB-first.
//   Observation j after the capture edge corresponds to cycle k+j.
module tb_led_chain_streamer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] frames_a, frames_b;
  logic       start_a, start_b;
  logic       dout_a, busy_a, done_a;
  logic       dout_b, busy_b, done_b;
  logic       led_idx_a, led_idx_b;

  int n_cmp  = 0;
  int n_fail = 0;

  // Expected dout sequences, cycle k+1 in the MSB position.
  localparam logic [36:0] P_A   = 37'b1110_1000_1110_1000_1000_1000_1000_1110_00000;
  localparam logic [36:0] P_B   = 37'b1000_1000_1000_1000_1110_1110_1110_1110_00000;
  localparam logic [36:0] P_ONE = 37'b1110_1110_1110_1110_1110_1110_1110_1110_00000;
  localparam logic [36:0] P_ZER = 37'b1000_1000_1000_1000_1000_1000_1000_1000_00000;
  localparam logic [36:0] P_LSB = 37'b1110_1000_1000_1000_1000_1000_1000_1000_00000;

  always #5 clk = ~clk;

  led_chain_streamer #(.N_LEDS(2), .W(4), .MSB_FIRST(1), .T0H(1), .T0L(3),
                       .T1H(3), .T1L(1), .T_RST(5)) dut_a (
    .clk(clk), .rst_n(rst_n), .frames(frames_a), .start(start_a),
    .dout(dout_a), .busy(busy_a), .done(done_a), .led_idx(led_idx_a)
  );

  led_chain_streamer #(.N_LEDS(2), .W(4), .MSB_FIRST(0), .T0H(1), .T0L(3),
                       .T1H(3), .T1L(1), .T_RST(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .frames(frames_b), .start(start_b),
    .dout(dout_b), .busy(busy_b), .done(done_b), .led_idx(led_idx_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called right after the capture edge. Checks observations k+1..k+37 and
  // the done cycle k+38; does not advance past the done cycle.
  task automatic run_ref(input string name, input logic [36:0] pat,
                         input int p1, input int p2, input bit hold,
                         input int chg_at, input logic [7:0] chg_val,
                         input bit chk_b);
    for (int j = 1; j <= 37; j++) begin
      chk($sformatf("%s dout k+%0d", name, j), 32'(dout_a), 32'(pat[37-j]));
      chk($sformatf("%s busy k+%0d", name, j), 32'(busy_a), 32'd1);
      chk($sformatf("%s done k+%0d", name, j), 32'(done_a), 32'd0);
      chk($sformatf("%s led_idx k+%0d", name, j), 32'(led_idx_a), (j >= 17) ? 32'd1 : 32'd0);
      if (chk_b) begin
        chk($sformatf("%s lsb dout k+%0d", name, j), 32'(dout_b), 32'(P_LSB[37-j]));
      end
      if (j == chg_at) frames_a = chg_val;
      start_a = hold || (j == p1) || (j == p2);
      start_b = 1'b0;
      tick();
    end
    chk($sformatf("%s done k+38", name), 32'(done_a), 32'd1);
    chk($sformatf("%s busy k+38", name), 32'(busy_a), 32'd0);
    chk($sformatf("%s dout k+38", name), 32'(dout_a), 32'd0);
    chk($sformatf("%s led_idx k+38", name), 32'(led_idx_a), 32'd0);
    if (chk_b) begin
      chk($sformatf("%s lsb done k+38", name), 32'(done_b), 32'd1);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    frames_a = 8'h00;
    frames_b = 8'h00;
    start_a  = 1'b0;
    start_b  = 1'b0;
    #2;
    tick();
    tick();
    chk("reset dout", 32'(dout_a), 32'd0);
    chk("reset busy", 32'(busy_a), 32'd0);
    chk("reset done", 32'(done_a), 32'd0);
    chk("reset led_idx", 32'(led_idx_a), 32'd0);
    chk("reset lsb dout", 32'(dout_b), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle dout", 32'(dout_a), 32'd0);
    chk("idle busy", 32'(busy_a), 32'd0);

    // Single refresh, LED0=1010 LED1=0001; LSB-first instance alongside.
    frames_a = {4'b0001, 4'b1010};
    frames_b = {4'b0000, 4'b0001};
    start_a  = 1'b1;
    start_b  = 1'b1;
    tick();
    run_ref("single", P_A, 0, 0, 1'b0, 0, 8'h00, 1'b1);
    tick();
    chk("single done drops", 32'(done_a), 32'd0);

    // Start pulses while busy must be ignored.
    start_a = 1'b1;
    tick();
    run_ref("busystart", P_A, 5, 30, 1'b0, 0, 8'h00, 1'b0);
    tick();
    chk("busystart no restart", 32'(busy_a), 32'd0);
    chk("busystart done once", 32'(done_a), 32'd0);

    // Continuous start; frames change at k+10, new data used at k+39.
    start_a = 1'b1;
    tick();
    run_ref("cont1", P_A, 0, 0, 1'b1, 10, {4'b1111, 4'b0000}, 1'b0);
    tick();
    run_ref("cont2", P_B, 0, 0, 1'b0, 0, 8'h00, 1'b0);
    tick();

    // Asynchronous reset in the middle of a high phase.
    frames_a = {4'b0001, 4'b1010};
    start_a  = 1'b1;
    tick();
    start_a = 1'b0;
    for (int j = 1; j < 11; j++) tick();
    chk("rst pre dout high", 32'(dout_a), 32'd1);
    chk("rst pre busy", 32'(busy_a), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst async dout", 32'(dout_a), 32'd0);
    chk("rst async busy", 32'(busy_a), 32'd0);
    chk("rst async led_idx", 32'(led_idx_a), 32'd0);
    for (int j = 0; j < 3; j++) begin
      tick();
      chk($sformatf("rst hold done %0d", j), 32'(done_a), 32'd0);
      chk($sformatf("rst hold dout %0d", j), 32'(dout_a), 32'd0);
    end
    rst_n = 1'b1;
    tick();
    chk("rst release idle", 32'(busy_a), 32'd0);
    start_a = 1'b1;
    tick();
    run_ref("afterrst", P_A, 0, 0, 1'b0, 0, 8'h00, 1'b0);
    tick();

    // All-ones and all-zeros frames: every bit is four cycles.
    frames_a = 8'hFF;
    start_a  = 1'b1;
    tick();
    run_ref("ones", P_ONE, 0, 0, 1'b0, 0, 8'h00, 1'b0);
    tick();
    frames_a = 8'h00;
    start_a  = 1'b1;
    tick();
    run_ref("zeros", P_ZER, 0, 0, 1'b0, 0, 8'h00, 1'b0);
    tick();
    chk("final idle busy", 32'(busy_a), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
